reg_trace_buffer: RTL and testbench

- Hardware register-write trace capture for the tiny CPU. Replaces per-cycle simulation printing of the register file.
- Sits beside the register file and snoops its write port (enable, address, data).
- Each captured write is stored as a timestamped entry in a FIFO and streamed out through a valid/ready interface.
- Downstream consumer is a debug UART or a bench monitor.

---
 rtl/reg_trace_buffer.sv | 108 ++++++++++
 tb/tb_reg_trace_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_trace_buffer.sv
// Register-write trace buffer: snoops the register-file write port and streams
// timestamped entries through a FWFT FIFO. Optional per-register mask: TRACE_FILTER_EN.
module reg_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     nRESET,
  input  logic                     trace_en,
  input  logic                     mode_wrap,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
`ifdef TRACE_FILTER_EN
  input  logic [2**ADDR_W-1:0]     reg_mask,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          out_ts,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [TS_W-1:0] ts;
  logic            push, pop, full, wr_mem, lost, rd_adv, cnt_inc, cnt_dec;

`ifdef TRACE_FILTER_EN
  assign push = trace_en && wr_en && reg_mask[wr_addr];
`else
  assign push = trace_en && wr_en;
`endif

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == CW'(DEPTH));

  // A full FIFO still accepts a push when the head leaves on the same edge;
  // in wrap mode the new entry lands on the head slot and the head moves on.
  always_comb begin
    wr_mem  = 1'b0;
    lost    = 1'b0;
    rd_adv  = 1'b0;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    if (!clear) begin
      wr_mem  = push && (!full || pop || mode_wrap);
      lost    = push && full && !pop;
      rd_adv  = pop || (lost && mode_wrap);
      cnt_inc = push && !pop && !full;
      cnt_dec = pop && !push;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_mem) mem[wr_ptr] <= '{ts: ts, addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (trace_en) ts <= ts + 1'b1;
      if (wr_mem)   wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv)   rd_ptr <= rd_ptr + 1'b1;
      if (cnt_inc)       count <= count + 1'b1;
      else if (cnt_dec)  count <= count - 1'b1;
      if (lost) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  assign head     = mem[rd_ptr];
  assign out_ts   = head.ts;
  assign out_addr = head.addr;
  assign out_data = head.data;
endmodule

// File: tb/tb_reg_trace_buffer.sv
// Bench for reg_trace_buffer: directed test-plan steps plus random traffic,
// all compared against a queue-based reference model.
module tb_reg_trace_buffer;
  localparam int DATA_W = 16, ADDR_W = 3, DEPTH = 16, TS_W = 16, DROP_W = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic nRESET, trace_en, mode_wrap, clear, wr_en, out_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [2**ADDR_W-1:0] reg_mask;
  logic out_valid, overflow;
  logic [TS_W-1:0] out_ts;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic [CW-1:0] count;
  logic [DROP_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  reg_trace_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .nRESET(nRESET), .trace_en(trace_en), .mode_wrap(mode_wrap), .clear(clear),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef TRACE_FILTER_EN
    .reg_mask(reg_mask),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts), .out_addr(out_addr),
    .out_data(out_data), .count(count), .overflow(overflow), .drop_cnt(drop_cnt));

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t            q[$];
  logic [TS_W-1:0] m_ts;
  int              m_drop;
  bit              m_ovf;
  int              checks = 0, errors = 0;
  logic [DATA_W-1:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete(); m_ts = '0; m_drop = 0; m_ovf = 0;
  endtask

  // Reference: pop the head first (only if something was there), then append;
  // a push that still finds the queue full is a loss.
  task automatic model_edge();
    bit do_push, do_pop;
    if (!nRESET || clear) begin
      model_reset();
      return;
    end
    do_pop  = (q.size() > 0) && out_ready;
    do_push = trace_en && wr_en;
`ifdef TRACE_FILTER_EN
    do_push = do_push && reg_mask[wr_addr];
`endif
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (q.size() < DEPTH) q.push_back('{m_ts, wr_addr, wr_data});
      else begin
        m_ovf = 1;
        if (m_drop < 2**DROP_W - 1) m_drop++;
        if (mode_wrap) begin
          void'(q.pop_front());
          q.push_back('{m_ts, wr_addr, wr_data});
        end
      end
    end
    if (trace_en) m_ts = m_ts + 1'b1;
  endtask

  task automatic check_all();
    chk("valid", out_valid, q.size() != 0);
    chk("count", count, q.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    if (q.size() != 0) begin
      chk("out_ts", out_ts, q[0].ts);
      chk("out_addr", out_addr, q[0].a);
      chk("out_data", out_data, q[0].d);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  // Drain with bounded cycles, recording what the consumer sees.
  task automatic drain();
    got.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 3 * DEPTH && out_valid; k++) begin
      got.push_back(out_data);
      step();
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 1'b0);
  endtask

  task automatic fill_run(input bit wrap, input int base);
    do_clear();
    mode_wrap = wrap;
    for (int i = 0; i < 20; i++) write(ADDR_W'(i), DATA_W'(i));
    chk("fill_count", count, DEPTH);
    chk("fill_ovf", overflow, 1'b1);
    chk("fill_drop", drop_cnt, 4);
    drain();
    chk("fill_drain_len", got.size(), DEPTH);
    for (int i = 0; i < got.size(); i++) chk("fill_order", got[i], base + i);
  endtask

  initial begin
    nRESET = 1'b1; trace_en = 0; mode_wrap = 0; clear = 0; wr_en = 0;
    wr_addr = '0; wr_data = '0; out_ready = 0; reg_mask = '1;
    #1 nRESET = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drop", drop_cnt, 0);
    @(negedge clk); @(negedge clk);
    nRESET = 1'b1;

    // single capture at ts = 5
    trace_en = 1'b1;
    repeat (5) step();
    write(3'd3, 16'h00A5);
    chk("cap_ts", out_ts, 5);
    chk("cap_addr", out_addr, 3);
    chk("cap_data", out_data, 16'h00A5);
    chk("cap_count", count, 1);
    drain();

    // drain ordering
    for (int i = 1; i <= 3; i++) write(ADDR_W'(i), DATA_W'(i));
    drain();
    chk("order_len", got.size(), 3);
    for (int i = 0; i < got.size(); i++) chk("order_data", got[i], i + 1);
    chk("order_count", count, 0);

    fill_run(1'b0, 0);
    fill_run(1'b1, 4);

    // full with simultaneous push/pop, then clear alongside a write
    do_clear();
    mode_wrap = 1'b0;
    for (int i = 0; i < DEPTH; i++) write(ADDR_W'(i), DATA_W'(16'h100 + i));
    out_ready = 1'b1;
    write(3'd7, 16'hBEEF);
    out_ready = 1'b0;
    chk("pp_count", count, DEPTH);
    chk("pp_drop", drop_cnt, 0);
    wr_en = 1'b1; wr_data = 16'hDEAD; clear = 1'b1;
    step();
    clear = 1'b0; wr_en = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_ovf", overflow, 1'b0);
    chk("clr_valid", out_valid, 1'b0);
    write(3'd1, 16'h1234);
    chk("clr_ts", out_ts, 0);
    drain();

`ifdef TRACE_FILTER_EN
    do_clear();
    reg_mask = 8'b0000_0100;
    for (int i = 1; i <= 3; i++) write(ADDR_W'(i), DATA_W'(i));
    chk("flt_count", count, 1);
    chk("flt_addr", out_addr, 2);
    chk("flt_drop", drop_cnt, 0);
    drain();
    reg_mask = '1;
`endif

    // random traffic, with one asynchronous reset mid-stream
    for (int it = 0; it < 600; it++) begin
      trace_en  = ($urandom_range(0, 9) != 0);
      mode_wrap = $urandom_range(0, 1);
      clear     = ($urandom_range(0, 79) == 0);
      wr_en     = ($urandom_range(0, 9) < 7);
      wr_addr   = ADDR_W'($urandom);
      wr_data   = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 9) < 3);
      reg_mask  = (2**ADDR_W)'($urandom);
      if (it == 300) begin
        nRESET = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_count", count, 0);
        model_reset();
        step();
        nRESET = 1'b1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
